// File: rtl/apb_uart_pkg.sv
// Shared constants for the APB UART register file: register indices,
// CTRL/STATUS bit positions and the APB slave sequencing states.
package apb_uart_pkg;

    localparam int unsigned REG_BAUD   = 0;
    localparam int unsigned REG_CTRL   = 1;
    localparam int unsigned REG_TXDATA = 2;
    localparam int unsigned REG_RXDATA = 3;
    localparam int unsigned REG_STATUS = 4;
    localparam int unsigned NUM_REGS   = 5;

    localparam int unsigned CTRL_TXIE = 0;
    localparam int unsigned CTRL_RXIE = 1;
    localparam int unsigned CTRL_RXEN = 2;

    localparam int unsigned STAT_TXRDY = 0;
    localparam int unsigned STAT_RXRDY = 1;
    localparam int unsigned STAT_OVR   = 2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETUP,
        S_ACCESS
    } apb_state_t;

endpackage

// File: rtl/apb_uart_regfile_if.sv
// APB3 bus bundle between the interconnect (master) and the UART register file (slave).
interface apb_uart_regfile_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 3
);
    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [ADDR_W-1:0] paddr;
    logic [DATA_W-1:0] pwdata;
    logic [DATA_W-1:0] prdata;
    logic              pready;
    logic              pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/apb_slave_fsm.sv
// APB slave phase sequencer: IDLE/SETUP/ACCESS with a wait-state counter.
// done marks the single cycle on which register side effects may happen.
module apb_slave_fsm
    import apb_uart_pkg::*;
#(
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic pclk,
    input  logic presetn,
    input  logic psel,
    input  logic penable,
    output logic pready,
    output logic done
);
    localparam logic [2:0] WS = 3'(WAIT_STATES);

    apb_state_t state;
    logic [2:0] cnt;

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (psel && !penable) state <= S_SETUP;
                end
                S_SETUP: begin
                    if (!psel) begin
                        state <= S_IDLE;
                    end else begin
                        state <= S_ACCESS;
                        cnt   <= WS;
                    end
                end
                S_ACCESS: begin
                    if (!psel || cnt == '0) state <= S_IDLE;
                    else                    cnt   <= cnt - 3'd1;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign pready = (state == S_ACCESS) && (cnt == '0);
    // A dropped psel abandons the transfer, so it never counts as completed.
    assign done   = pready && psel;

endmodule

// File: rtl/apb_uart_regfile.sv
// APB3 register file for the UART core: baud divisor, control, TX launch,
// single-byte RX holding register and status with sticky overrun.
module apb_uart_regfile
    import apb_uart_pkg::*;
#(
    parameter int unsigned       DATA_W      = 8,
    parameter int unsigned       ADDR_W      = 3,
    parameter int unsigned       WAIT_STATES = 0,
    parameter logic [DATA_W-1:0] BAUD_RST    = DATA_W'(8'h1A)
) (
    input  logic                pclk,
    input  logic                presetn,
    apb_uart_regfile_if.slave   apb,
    output logic [DATA_W-1:0]   baud_val,
    output logic [7:0]          tx_data,
    output logic                tx_wr,
    input  logic                tx_full,
    input  logic [7:0]          rx_data,
    input  logic                rx_valid,
    output logic                irq
);
    logic              done;
    logic              err;
    logic [31:0]       idx;
    logic [DATA_W-1:0] rd_val;
    logic [2:0]        ctrl;
    logic [7:0]        rx_hold;
    logic              rx_full;
    logic              ovr;
    logic              wr_ok;
    logic              rd_pop;
    logic              rx_cap;
    logic              ovr_set;
    logic              ovr_clr;

    apb_slave_fsm #(.WAIT_STATES(WAIT_STATES)) u_fsm (
        .pclk    (pclk),
        .presetn (presetn),
        .psel    (apb.psel),
        .penable (apb.penable),
        .pready  (apb.pready),
        .done    (done)
    );

    assign idx = 32'(apb.paddr);

    always_comb begin
        err = 1'b0;
        if (idx >= NUM_REGS)                                 err = 1'b1;
        else if (apb.pwrite && idx == REG_RXDATA)            err = 1'b1;
        else if (apb.pwrite && idx == REG_TXDATA && tx_full) err = 1'b1;
    end

    always_comb begin
        rd_val = '0;
        case (idx)
            REG_BAUD:   rd_val = baud_val;
            REG_CTRL:   rd_val = DATA_W'(ctrl);
            REG_RXDATA: rd_val = DATA_W'(rx_hold);
            REG_STATUS: rd_val = DATA_W'({ovr, rx_full, !tx_full});
            default:    rd_val = '0;
        endcase
    end

    assign apb.pslverr = done && err;
    assign wr_ok   = done && apb.pwrite && !err;
    assign rd_pop  = done && !apb.pwrite && idx == REG_RXDATA;
    assign rx_cap  = rx_valid && ctrl[CTRL_RXEN];
    // A pop on the capture cycle makes room for the new byte, so no overrun.
    assign ovr_set = rx_cap && rx_full && !rd_pop;
    assign ovr_clr = wr_ok && idx == REG_STATUS && apb.pwdata[STAT_OVR];

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            apb.prdata <= '0;
            baud_val   <= BAUD_RST;
            ctrl       <= '0;
            tx_data    <= '0;
            tx_wr      <= 1'b0;
            rx_hold    <= '0;
            rx_full    <= 1'b0;
            ovr        <= 1'b0;
            irq        <= 1'b0;
        end else begin
            tx_wr <= 1'b0;
            if (done && !apb.pwrite) apb.prdata <= rd_val;
            if (wr_ok) begin
                case (idx)
                    REG_BAUD: baud_val <= apb.pwdata;
                    REG_CTRL: ctrl     <= apb.pwdata[2:0];
                    REG_TXDATA: begin
                        tx_data <= apb.pwdata[7:0];
                        tx_wr   <= 1'b1;
                    end
                    default: ;
                endcase
            end
            if (rx_cap) begin
                rx_hold <= rx_data;
                rx_full <= 1'b1;
            end else if (rd_pop) begin
                rx_full <= 1'b0;
            end
            ovr <= ovr_set || (ovr && !ovr_clr);
            irq <= (ctrl[CTRL_TXIE] && !tx_full) || (ctrl[CTRL_RXIE] && rx_full) || ovr;
        end
    end

endmodule
